// File: rtl/mmio_bank.sv
// mmio_bank: memory-mapped I/O register bank on the HACK data-memory bus.
// The window starts at BASE and is laid out as follows:
//   offset 0..NOUT-1 : output registers, read/write, driven onto out_pins
//   offset NOUT      : input register, read-only (synchronised in_pins)
//   offset NOUT+1    : sticky rising-edge event register, write-1-to-clear
// The event register only exists when MMIO_BANK_EDGE_EN is defined. Without
// it the window shrinks to NOUT+1 words and offset NOUT+1 is undecoded.
// Reads are registered and return the value held before any same-cycle write.
module mmio_bank #(
  parameter int unsigned BASE = 32'h7400,
  parameter int unsigned AW   = 15,
  parameter int unsigned DW   = 16,
  parameter int unsigned NOUT = 4
) (
  input  logic                 clk50m,
  input  logic                 rst,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 we,
  input  logic [DW-1:0]        in_pins,
  output logic [NOUT*DW-1:0]   out_pins,
  output logic [DW-1:0]        rd_data,
  output logic                 sel
);

`ifdef MMIO_BANK_EDGE_EN
  localparam int unsigned NWIN = NOUT + 2;
`else
  localparam int unsigned NWIN = NOUT + 1;
`endif

  localparam logic [AW-1:0] BASE_A = AW'(BASE);
  localparam logic [AW-1:0] LAST_A = AW'(BASE + NWIN - 1);
  localparam logic [AW-1:0] OFF_IN = AW'(NOUT);

  logic [AW-1:0] offset;
  logic          in_win;
  logic [DW-1:0] out_reg [NOUT];
  logic [DW-1:0] s1;
  logic [DW-1:0] s2;
  logic [DW-1:0] rd_next;

  // Offset is taken modulo 2^AW; it is only meaningful while in_win is set.
  assign offset = addr - BASE_A;
  assign in_win = (addr >= BASE_A) && (addr <= LAST_A);

  // Output registers: load on a decoded write to their own offset.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      for (int i = 0; i < int'(NOUT); i++) out_reg[i] <= '0;
    end else if (we && in_win) begin
      for (int i = 0; i < int'(NOUT); i++) begin
        if (offset == AW'(i)) out_reg[i] <= wr_data;
      end
    end
  end

  for (genvar g = 0; g < int'(NOUT); g++) begin : g_out
    assign out_pins[g*DW +: DW] = out_reg[g];
  end

  // Two-flop synchroniser for the asynchronous board inputs.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_pins;
      s2 <= s1;
    end
  end

`ifdef MMIO_BANK_EDGE_EN
  localparam logic [AW-1:0] OFF_EV = AW'(NOUT + 1);

  logic [DW-1:0] s3;
  logic [DW-1:0] ev;
  logic [DW-1:0] rise;
  logic [DW-1:0] clr;

  assign rise = s2 & ~s3;
  assign clr  = (we && in_win && (offset == OFF_EV)) ? wr_data : '0;

  // Edge-detect delay and sticky event bits; a new rise overrides a clear.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      s3 <= '0;
      ev <= '0;
    end else begin
      s3 <= s2;
      ev <= (ev & ~clr) | rise;
    end
  end
`endif

  // Read mux over the pre-edge register contents; undecoded reads give zero.
  always_comb begin
    rd_next = '0;
    if (in_win) begin
      for (int i = 0; i < int'(NOUT); i++) begin
        if (offset == AW'(i)) rd_next = out_reg[i];
      end
      if (offset == OFF_IN) rd_next = s2;
`ifdef MMIO_BANK_EDGE_EN
      if (offset == OFF_EV) rd_next = ev;
`endif
    end
  end

  // Registered read data and window-hit flag for the top-level read mux.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      rd_data <= '0;
      sel     <= 1'b0;
    end else begin
      rd_data <= rd_next;
      sel     <= in_win;
    end
  end

endmodule

// File: tb/tb_mmio_bank.sv
// tb_mmio_bank: directed scoreboard bench for mmio_bank (NOUT=4, BASE=15'h7400).
// Expected read results are queued when an address is driven and checked one
// edge later; out_pins is checked against a register model every cycle.
module tb_mmio_bank;
  localparam int AW   = 15;
  localparam int DW   = 16;
  localparam int NOUT = 4;

  logic              clk50m = 1'b0;
  logic              rst = 1'b1;
  logic [AW-1:0]     addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              we = 1'b0;
  logic [DW-1:0]     in_pins = '0;
  logic [NOUT*DW-1:0] out_pins;
  logic [DW-1:0]     rd_data;
  logic              sel;

  always #5 clk50m = ~clk50m;

  mmio_bank #(.BASE(15'h7400), .AW(AW), .DW(DW), .NOUT(NOUT)) dut (
    .clk50m(clk50m), .rst(rst), .addr(addr), .wr_data(wr_data), .we(we),
    .in_pins(in_pins), .out_pins(out_pins), .rd_data(rd_data), .sel(sel)
  );

  typedef struct packed {
    logic [DW-1:0] rd;
    logic          hit;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] m_out [NOUT];
  logic [DW-1:0] m_in = '0;
  logic [DW-1:0] m_ev = '0;

  function automatic exp_t exp_read(input logic [AW-1:0] a);
    exp_t e;
    e.rd  = '0;
    e.hit = 1'b0;
    if (a inside {[15'h7400:15'h7403]}) begin
      e.rd  = m_out[a[1:0]];
      e.hit = 1'b1;
    end else if (a == 15'h7404) begin
      e.rd  = m_in;
      e.hit = 1'b1;
    end
`ifdef MMIO_BANK_EDGE_EN
    else if (a == 15'h7405) begin
      e.rd  = m_ev;
      e.hit = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic w);
    exp_t e;
    @(negedge clk50m);
    addr    = a;
    wr_data = d;
    we      = w;
    sb.push_back(exp_read(a));
    @(posedge clk50m);
    #1;
    if (w && (a inside {[15'h7400:15'h7403]})) m_out[a[1:0]] = d;
`ifdef MMIO_BANK_EDGE_EN
    if (w && a == 15'h7405) m_ev = m_ev & ~d;
`endif
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".rd_data"}, 64'(rd_data), 64'(e.rd));
      chk({tag, ".sel"}, 64'(sel), 64'(e.hit));
    end else begin
      bad++;
      $error("FAIL %s scoreboard empty observed=%h", tag, rd_data);
    end
    chk({tag, ".out_pins"}, 64'(out_pins), {m_out[3], m_out[2], m_out[1], m_out[0]});
  endtask

  initial begin
    for (int i = 0; i < NOUT; i++) m_out[i] = '0;

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk50m);
    #1;
    chk("reset.out_pins", 64'(out_pins), 64'h0);
    chk("reset.rd_data", 64'(rd_data), 64'h0);
    chk("reset.sel", 64'(sel), 64'h0);
    @(negedge clk50m);
    rst = 1'b0;

    // reset then write / read back
    cyc("wr7401", 15'h7401, 16'hA5A5, 1'b1);
    cyc("rd7401", 15'h7401, 16'h0000, 1'b0);

    // same-cycle read returns the old value
    cyc("wr7400a", 15'h7400, 16'h0001, 1'b1);
    cyc("wr7400b", 15'h7400, 16'h0002, 1'b1);
    cyc("rd7400", 15'h7400, 16'h0000, 1'b0);
    cyc("wr7403", 15'h7403, 16'hFFFF, 1'b1);
    cyc("wr7402", 15'h7402, 16'h1234, 1'b1);
    cyc("rd7403", 15'h7403, 16'h0000, 1'b0);
    cyc("rd7402", 15'h7402, 16'h0000, 1'b0);

    // decode bounds and read-only input register
    cyc("wr73ff", 15'h73FF, 16'hDEAD, 1'b1);
    cyc("wr7406", 15'h7406, 16'hBEEF, 1'b1);
    cyc("wr7404", 15'h7404, 16'h5555, 1'b1);
    cyc("rd7fff", 15'h7FFF, 16'h0000, 1'b0);
    cyc("rd0000", 15'h0000, 16'h0000, 1'b0);
    cyc("rd7405", 15'h7405, 16'h0000, 1'b0);

    // input synchroniser latency and event capture
    in_pins = 16'h0081;
    cyc("sync1", 15'h7404, 16'h0000, 1'b0);
    cyc("sync2", 15'h7404, 16'h0000, 1'b0);
    m_in = 16'h0081;
    cyc("sync3", 15'h7404, 16'h0000, 1'b0);
`ifdef MMIO_BANK_EDGE_EN
    m_ev = 16'h0081;
`endif
    cyc("ev_rd", 15'h7405, 16'h0000, 1'b0);

    // set beats a simultaneous clear, then a later clear takes effect
    in_pins = 16'h0089;
    cyc("sbc1", 15'h7400, 16'h0000, 1'b0);
    cyc("sbc2", 15'h7400, 16'h0000, 1'b0);
    m_in = 16'h0089;
    cyc("sbc_wr", 15'h7405, 16'h0008, 1'b1);
`ifdef MMIO_BANK_EDGE_EN
    m_ev = m_ev | 16'h0008;
`endif
    cyc("sbc_rd", 15'h7405, 16'h0000, 1'b0);
    cyc("clr_wr", 15'h7405, 16'h0008, 1'b1);
    cyc("clr_rd", 15'h7405, 16'h0000, 1'b0);
    cyc("clr_all", 15'h7405, 16'h0081, 1'b1);
    cyc("clr_rd2", 15'h7405, 16'h0000, 1'b0);
    cyc("rdin", 15'h7404, 16'h0000, 1'b0);

    // mid-stream reset clears everything
    @(negedge clk50m);
    rst     = 1'b1;
    addr    = 15'h7401;
    we      = 1'b0;
    @(posedge clk50m);
    #1;
    chk("rst2.out_pins", 64'(out_pins), 64'h0);
    chk("rst2.rd_data", 64'(rd_data), 64'h0);
    chk("rst2.sel", 64'(sel), 64'h0);
    for (int i = 0; i < NOUT; i++) m_out[i] = '0;
    m_in = '0;
    m_ev = '0;
    @(negedge clk50m);
    rst = 1'b0;
    cyc("post_rst_in", 15'h7404, 16'h0000, 1'b0);
    cyc("post_rst_out", 15'h7401, 16'h0000, 1'b0);

    @(negedge clk50m);
    we = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
